// File: rtl/output_matrix_streamer.sv
// output_matrix_streamer: snapshots an accumulated ROWS x COLS matrix on start,
// requantizes each element (arithmetic shift + signed saturation) and drains it
// one row per valid/ready transfer.
module output_matrix_streamer #(
    parameter int WORD_SIZE = 16,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 0,
    parameter int ROWS      = 4,
    parameter int COLS      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ROWS*COLS*WORD_SIZE-1:0] matrix_in,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [COLS*OUT_WIDTH-1:0]      out_data,
    output logic [$clog2(ROWS):0]          out_row,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           sat_flag
);

    localparam int RW       = $clog2(ROWS) + 1;
    localparam int ROW_BITS = COLS * WORD_SIZE;

    // Saturation bounds expressed at the input word width so the comparison
    // happens on the shifted value before any truncation.
    localparam logic signed [WORD_SIZE-1:0] QMAX = WORD_SIZE'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [WORD_SIZE-1:0] QMIN = WORD_SIZE'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic                           capture;
    logic                           load;
    logic                           finish;
    logic [ROWS*COLS*WORD_SIZE-1:0] snap;
    logic [RW-1:0]                  load_idx;
    logic [ROW_BITS-1:0]            row_word;
    logic [COLS*OUT_WIDTH-1:0]      load_data;
    logic                           load_sat;
    logic signed [WORD_SIZE-1:0]    elem;
    logic signed [WORD_SIZE-1:0]    shifted;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control strobes: capture on start, load a row on entry
    // to streaming and after every non-final transfer, finish on the last one.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                load       = 1'b1;
                next_state = STREAM;
            end
            STREAM: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Snapshot buffer; deliberately not reset so it costs no reset routing.
    always_ff @(posedge clk) begin
        if (capture) begin
            snap <= matrix_in;
        end
    end

    // Select the row about to be loaded: row 0 from LOAD, otherwise the
    // successor of the row currently presented.
    always_comb begin
        load_idx = (state == LOAD) ? '0 : out_row + RW'(1);
        row_word = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (load_idx == RW'(r)) begin
                row_word = snap[r*ROW_BITS +: ROW_BITS];
            end
        end
    end

    // Requantize the selected row: sign-extending shift, then clamp to the
    // signed output range, flagging any element that clamped.
    always_comb begin
        load_data = '0;
        load_sat  = 1'b0;
        elem      = '0;
        shifted   = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            elem    = row_word[c*WORD_SIZE +: WORD_SIZE];
            shifted = elem >>> SHIFT;
            if (shifted > QMAX) begin
                load_data[c*OUT_WIDTH +: OUT_WIDTH] = QMAX[OUT_WIDTH-1:0];
                load_sat = 1'b1;
            end else if (shifted < QMIN) begin
                load_data[c*OUT_WIDTH +: OUT_WIDTH] = QMIN[OUT_WIDTH-1:0];
                load_sat = 1'b1;
            end else begin
                load_data[c*OUT_WIDTH +: OUT_WIDTH] = shifted[OUT_WIDTH-1:0];
            end
        end
    end

    // Registered output stage: row presentation, status and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            done <= finish;
            if (capture) begin
                busy     <= 1'b1;
                sat_flag <= 1'b0;
            end
            if (load) begin
                out_data  <= load_data;
                out_row   <= load_idx;
                out_valid <= 1'b1;
                out_last  <= (load_idx == RW'(ROWS - 1));
                sat_flag  <= sat_flag | load_sat;
            end
            if (finish) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_matrix_streamer.sv
// Directed bench: one pass-through instance (16-bit out, no shift) and one
// requantizing instance (8-bit out, shift 2) share all inputs.
module tb_output_matrix_streamer;

    logic         clk;
    logic         rst;
    logic         start;
    logic [255:0] matrix_in;
    logic         out_ready;

    logic         p_valid, p_last, p_busy, p_done, p_sat;
    logic [63:0]  p_data;
    logic [2:0]   p_row;
    logic         q_valid, q_last, q_busy, q_done, q_sat;
    logic [31:0]  q_data;
    logic [2:0]   q_row;

    int checks;
    int failures;

    logic [63:0] exp_p  [4];
    logic [31:0] exp_q  [4];
    logic        exp_qs [4];

    output_matrix_streamer #(
        .WORD_SIZE(16), .OUT_WIDTH(16), .SHIFT(0), .ROWS(4), .COLS(4)
    ) dut_p (
        .clk(clk), .rst(rst), .start(start), .matrix_in(matrix_in),
        .out_ready(out_ready), .out_valid(p_valid), .out_data(p_data),
        .out_row(p_row), .out_last(p_last), .busy(p_busy), .done(p_done),
        .sat_flag(p_sat)
    );

    output_matrix_streamer #(
        .WORD_SIZE(16), .OUT_WIDTH(8), .SHIFT(2), .ROWS(4), .COLS(4)
    ) dut_q (
        .clk(clk), .rst(rst), .start(start), .matrix_in(matrix_in),
        .out_ready(out_ready), .out_valid(q_valid), .out_data(q_data),
        .out_row(q_row), .out_last(q_last), .busy(q_busy), .done(q_done),
        .sat_flag(q_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Matrix A: [r][c] = r*4+c. Shifted right by 2 every element of row r is r.
    task automatic load_a();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                matrix_in[(r*4+c)*16 +: 16] = 16'(r*4 + c);
                exp_p[r][c*16 +: 16]        = 16'(r*4 + c);
                exp_q[r][c*8 +: 8]          = 8'(r);
            end
            exp_qs[r] = 1'b0;
        end
    endtask

    // Matrix B: row 0 = 400,-400,100,-3 ; row 1 = 1000,-1000,0,0 ; rest 0.
    task automatic load_b();
        matrix_in = '0;
        matrix_in[0*16 +: 16] = 16'h0190;
        matrix_in[1*16 +: 16] = 16'hFE70;
        matrix_in[2*16 +: 16] = 16'h0064;
        matrix_in[3*16 +: 16] = 16'hFFFD;
        matrix_in[4*16 +: 16] = 16'h03E8;
        matrix_in[5*16 +: 16] = 16'hFC18;
        exp_p[0] = 64'hFFFD_0064_FE70_0190;
        exp_p[1] = 64'h0000_0000_FC18_03E8;
        exp_p[2] = 64'h0;
        exp_p[3] = 64'h0;
        exp_q[0] = 32'hFF19_9C64;   // -1, 25, -100, 100
        exp_q[1] = 32'h0000_807F;   // 0, 0, -128, 127
        exp_q[2] = 32'h0;
        exp_q[3] = 32'h0;
        exp_qs[0] = 1'b0;
        exp_qs[1] = 1'b1;
        exp_qs[2] = 1'b1;
        exp_qs[3] = 1'b1;
    endtask

    task automatic check_row(input int r);
        check("p_valid", 64'(p_valid), 64'd1);
        check("p_row",   64'(p_row),   64'(r));
        check("p_data",  p_data,       exp_p[r]);
        check("p_last",  64'(p_last),  64'(r == 3));
        check("p_busy",  64'(p_busy),  64'd1);
        check("p_done",  64'(p_done),  64'd0);
        check("p_sat",   64'(p_sat),   64'd0);
        check("q_valid", 64'(q_valid), 64'd1);
        check("q_row",   64'(q_row),   64'(r));
        check("q_data",  64'(q_data),  64'(exp_q[r]));
        check("q_sat",   64'(q_sat),   64'(exp_qs[r]));
    endtask

    // Pulse start, confirm one-cycle gap, end right after the edge that
    // presents row 0.
    task automatic begin_stream();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lat_busy",  64'(p_busy),  64'd1);
        check("lat_valid", 64'(p_valid), 64'd0);
        check("lat_qsat",  64'(q_sat),   64'd0);
        tick();
    endtask

    // Drain four rows; optional stall on one row and an overwrite+start poke
    // while another row is presented. Ends in the done cycle.
    task automatic drain(input int stall_row, input int stalls, input int poke_row);
        for (int r = 0; r < 4; r++) begin
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int s = 0; s < stalls; s++) begin
                    check_row(r);
                    tick();
                end
                out_ready = 1'b1;
            end
            check_row(r);
            if (r == poke_row) begin
                start = 1'b1;
                for (int i = 0; i < 16; i++) matrix_in[i*16 +: 16] = 16'h7FFF;
            end
            tick();
            start = 1'b0;
        end
        check("end_done",  64'(p_done),  64'd1);
        check("end_valid", 64'(p_valid), 64'd0);
        check("end_busy",  64'(p_busy),  64'd0);
        check("end_qdone", 64'(q_done),  64'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 64'(p_valid), 64'd0);
        check({tag, "_busy"},  64'(p_busy),  64'd0);
        check({tag, "_done"},  64'(p_done),  64'd0);
        check({tag, "_qdone"}, 64'(q_done),  64'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        matrix_in = '0;
        tick();
        tick();
        check("rst_valid", 64'(p_valid), 64'd0);
        check("rst_busy",  64'(p_busy),  64'd0);
        check("rst_done",  64'(p_done),  64'd0);
        check("rst_sat",   64'(q_sat),   64'd0);
        check("rst_row",   64'(p_row),   64'd0);
        check("rst_data",  p_data,       64'd0);
        check("rst_last",  64'(p_last),  64'd0);
        rst = 1'b0;
        tick();

        // Basic stream.
        load_a();
        begin_stream();
        drain(-1, 0, -1);
        tick();
        check_quiet("s1_after");

        // Backpressure: three stall cycles on row 1.
        begin_stream();
        drain(1, 3, -1);
        tick();
        check_quiet("s2_after");

        // Quantize/saturate, then restart in the done cycle with matrix A.
        load_b();
        begin_stream();
        drain(-1, 0, -1);
        check("s3_qsat_end", 64'(q_sat), 64'd1);
        load_a();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s6_busy",  64'(p_busy),  64'd1);
        check("s6_valid", 64'(p_valid), 64'd0);
        check("s6_done",  64'(p_done),  64'd0);
        check("s6_qsat",  64'(q_sat),   64'd0);
        tick();
        drain(-1, 0, -1);

        // Snapshot isolation: overwrite matrix and pulse start during row 2.
        tick();
        begin_stream();
        drain(-1, 0, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_quiet("s4_after");
        end

        // Reset mid-stream after the row-1 transfer.
        load_b();
        begin_stream();
        tick();
        check("s5_qsat_row1", 64'(q_sat), 64'd1);
        tick();
        check("s5_row2", 64'(p_row), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("s5_rst");
        check("s5_qsat", 64'(q_sat), 64'd0);
        check("s5_psat", 64'(p_sat), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet("s5_idle");
        end
        load_a();
        begin_stream();
        drain(-1, 0, -1);
        tick();
        check_quiet("s5_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_matrix_streamer.md
Name: output_matrix_streamer

Overview:
Downstream drain stage for the systolic matmul output-collection block.
- Snapshots the fully accumulated ROWS x COLS output matrix on a start pulse.
- Requantizes each element with an arithmetic right shift and signed saturation.
- Streams the result one row per transfer over a valid/ready interface to the result writer or host.
- The snapshot lets the collection block clear and reuse its matrix while this block drains.

Parameters:
WORD_SIZE, 16, signed width of each accumulated element in the input matrix
OUT_WIDTH, 8, signed width of each streamed element (1..WORD_SIZE)
SHIFT, 0, arithmetic right-shift amount applied before saturation (0..WORD_SIZE-1)
ROWS, `ROWS, output matrix rows
COLS, `COLS, output matrix columns

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  pulse; request snapshot and stream of matrix_in
matrix_in  input  ROWS*COLS*WORD_SIZE  flattened matrix; element [r][c] at bits ((r*COLS+c)*WORD_SIZE) +: WORD_SIZE
out_ready  input  1  downstream accepts the current row
out_valid  output  1  out_data holds a valid row
out_data  output  COLS*OUT_WIDTH  row data; column c at bits (c*OUT_WIDTH) +: OUT_WIDTH
out_row  output  $clog2(ROWS)+1  row index of out_data
out_last  output  1  out_data is row ROWS-1
busy  output  1  high from accepted start until the final row transfer
done  output  1  one-cycle pulse after the final row transfer
sat_flag  output  1  sticky per stream; any element of the stream saturated

Behaviour:
- Reset: state IDLE; out_valid, out_last, busy, done and sat_flag = 0; out_row = 0; out_data = 0; snapshot buffer not cleared.
- rst overrides everything, including mid-stream. The partially streamed matrix is discarded with no done pulse.
- States: IDLE, LOAD, STREAM.
- IDLE -> LOAD: on an edge where start = 1.
  - matrix_in is captured into the snapshot buffer on that edge.
  - busy = 1 and sat_flag = 0 from that edge.
- LOAD -> STREAM: on the next edge.
  - out_data <= quant(row 0), out_row <= 0, out_valid <= 1, out_last <= (ROWS == 1).
  - sat_flag |= saturation on row 0.
- Latency: start sampled at edge k gives out_valid = 1 after edge k+1.
- STREAM: a transfer occurs on an edge with out_valid & out_ready.
  - Transfer of row r < ROWS-1: load row r+1 on the same edge. Back-to-back, no bubble.
  - Transfer of row ROWS-1: -> IDLE, out_valid <= 0, busy <= 0, done <= 1 for exactly one cycle.
- Handshake: while out_valid & !out_ready, out_data, out_row and out_last hold stable. out_valid never drops without a transfer (except on rst).
- start while busy: ignored and not queued. Changes to matrix_in after the capture edge have no effect on the stream.
- start in the done cycle (state IDLE): accepted normally.
- quant(x), per element, signed:
  - y = x >>> SHIFT (sign-extending).
  - y > 2^(OUT_WIDTH-1)-1 gives 2^(OUT_WIDTH-1)-1. y < -2^(OUT_WIDTH-1) gives -2^(OUT_WIDTH-1). Otherwise y truncated to OUT_WIDTH bits.
  - Any clamp in a loaded row sets sat_flag. It stays set until the next accepted start or rst.
- OUT_WIDTH = WORD_SIZE with SHIFT = 0: exact pass-through, sat_flag never set.
- sat_flag and out_data are registered outputs; there is no combinational path from the inputs to any output.

Test Plan:
1. Basic stream: defaults with OUT_WIDTH=16, SHIFT=0, 4x4 matrix [r][c] = r*4+c, out_ready=1, start pulse at edge 0 -> valid after edge 1; rows {0,1,2,3}, {4,5,6,7}, {8..11}, {12..15} on consecutive cycles; out_last only on row 3; done one cycle after the row-3 edge; sat_flag=0.
2. Backpressure: same stimulus, out_ready low for 3 cycles on row 1 -> out_data={4,5,6,7} and out_row=1 held stable for all 3 cycles; no row skipped or duplicated; done occurs 3 cycles later than in scenario 1.
3. Quantize/saturate: OUT_WIDTH=8, SHIFT=2, elements 400, -400, 100, -3 -> 100, -100, 25, -1. Elements 1000 and -1000 -> 127 and -128, with sat_flag=1 from the row containing them.
4. Snapshot isolation and start while busy: change matrix_in to all 0x7FFF and pulse start during row 2 -> streamed rows still match the original snapshot; exactly one done; no second stream.
5. Reset mid-stream: assert rst after the row-1 transfer -> out_valid, busy and sat_flag are 0 the next cycle; no done pulse. A new start then streams from row 0.
6. Restart in the done cycle: pulse start in the cycle done=1 -> new stream begins (valid after edge+1) with the new matrix_in values; sat_flag is cleared at that start.
